rice_core_id_stage: RTL and testbench

Instruction-decode stage of the rice core pipeline, directly upstream of the execute stage. It holds the 31×XLEN integer register file (x0 hardwired to zero) and decodes one RV32I instruction per cycle from the fetch stage. It registers the operands, immediate, ALU command and memory-access descriptor that the execute stage consumes, and it obeys the execute stage's stall and flush requests.

---
 rtl/rice_core_id_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rice_core_id_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rice_core_id_stage.sv
// rice_core_id_stage: RV32I decode stage with a 31-entry register file and one output register.
// Optional same-cycle writeback bypass: define RICE_CORE_ID_RF_BYPASS_EN.
module rice_core_id_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  input  logic            i_if_valid,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [31:0]     i_if_inst,
  output logic            o_stall,
  input  logic            i_ex_stall,
  input  logic            i_flush,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_value,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_imm_value,
  output logic [3:0]      o_alu_command,
  output logic            o_alu_src_imm,
  output logic [1:0]      o_mem_access_type,
  output logic [2:0]      o_mem_access_size,
  output logic            o_illegal
);

  localparam int unsigned NUM_REGS = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_NONE     = 4'd0,
    ALU_ADD      = 4'd1,
    ALU_SUB      = 4'd2,
    ALU_SLL      = 4'd3,
    ALU_SLT      = 4'd4,
    ALU_SLTU     = 4'd5,
    ALU_XOR      = 4'd6,
    ALU_SRL      = 4'd7,
    ALU_SRA      = 4'd8,
    ALU_OR       = 4'd9,
    ALU_AND      = 4'd10,
    ALU_PASS_IMM = 4'd11
  } alu_cmd_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_type_e;

  logic [XLEN-1:0] rf [1:NUM_REGS-1];

  logic [6:0]      opcode;
  logic [4:0]      rd_f;
  logic [2:0]      f3;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;

  alu_cmd_e        f3_alu;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_imm;
  alu_cmd_e        dec_alu;
  logic            dec_src_imm;
  mem_type_e       dec_mem;
  logic [2:0]      dec_size;
  logic            dec_illegal;

  logic [XLEN-1:0] rs1_rf;
  logic [XLEN-1:0] rs2_rf;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            bubble;
  logic            hold_hit_rs1;
  logic            hold_hit_rs2;

  assign opcode = i_if_inst[6:0];
  assign rd_f   = i_if_inst[11:7];
  assign f3     = i_if_inst[14:12];
  assign rs1_f  = i_if_inst[19:15];
  assign rs2_f  = i_if_inst[24:20];
  assign f7     = i_if_inst[31:25];
  assign imm_i  = XLEN'($signed(i_if_inst[31:20]));
  assign imm_s  = XLEN'($signed({i_if_inst[31:25], i_if_inst[11:7]}));
  assign imm_u  = XLEN'($signed({i_if_inst[31:12], 12'b0}));

  // funct3 to ALU op shared by OP and OP-IMM; funct7[5] picks the arithmetic right shift
  always_comb begin
    f3_alu = ALU_NONE;
    case (f3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = f7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  end

  // Instruction decode; illegal encodings collapse to an inert bundle
  always_comb begin
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_rd      = '0;
    dec_imm     = '0;
    dec_alu     = ALU_NONE;
    dec_src_imm = 1'b0;
    dec_mem     = MEM_NONE;
    dec_size    = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_rd      = rd_f;
        dec_imm     = imm_u;
        dec_alu     = ALU_PASS_IMM;
        dec_src_imm = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_rs1     = rs1_f;
        dec_rd      = rd_f;
        dec_imm     = imm_i;
        dec_src_imm = 1'b1;
        dec_alu     = f3_alu;
        if (f3 == 3'b001) begin
          dec_illegal = (f7 != F7_ZERO);
        end else if (f3 == 3'b101) begin
          dec_illegal = !((f7 == F7_ZERO) || (f7 == F7_ALT));
        end
      end
      OPC_OP: begin
        dec_rs1     = rs1_f;
        dec_rs2     = rs2_f;
        dec_rd      = rd_f;
        dec_alu     = ((f3 == 3'b000) && f7[5]) ? ALU_SUB : f3_alu;
        dec_illegal = !((f7 == F7_ZERO) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_LOAD: begin
        dec_rs1  = rs1_f;
        dec_rd   = rd_f;
        dec_imm  = imm_i;
        dec_mem  = MEM_LOAD;
        dec_size = f3;
      end
      OPC_STORE: begin
        dec_rs1  = rs1_f;
        dec_rs2  = rs2_f;
        dec_imm  = imm_s;
        dec_mem  = MEM_STORE;
        dec_size = f3;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_rs1     = '0;
      dec_rs2     = '0;
      dec_rd      = '0;
      dec_imm     = '0;
      dec_alu     = ALU_NONE;
      dec_src_imm = 1'b0;
      dec_mem     = MEM_NONE;
      dec_size    = '0;
    end
  end

  // Operand read with optional writeback forwarding or hazard bubble
  always_comb begin
    rs1_rf = (dec_rs1 == '0) ? '0 : rf[dec_rs1];
    rs2_rf = (dec_rs2 == '0) ? '0 : rf[dec_rs2];
`ifdef RICE_CORE_ID_RF_BYPASS_EN
    rs1_val = (i_wb_valid && (dec_rs1 != '0) && (i_wb_rd == dec_rs1)) ? i_wb_value : rs1_rf;
    rs2_val = (i_wb_valid && (dec_rs2 != '0) && (i_wb_rd == dec_rs2)) ? i_wb_value : rs2_rf;
    bubble  = 1'b0;
`else
    rs1_val = rs1_rf;
    rs2_val = rs2_rf;
    bubble  = i_if_valid && i_wb_valid && (i_wb_rd != '0) &&
              ((i_wb_rd == dec_rs1) || (i_wb_rd == dec_rs2));
`endif
  end

  assign o_stall      = i_ex_stall || (bubble && !i_rst);
  assign hold_hit_rs1 = i_wb_valid && (i_wb_rd != '0) && (i_wb_rd == o_rs1);
  assign hold_hit_rs2 = i_wb_valid && (i_wb_rd != '0) && (i_wb_rd == o_rs2);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (i_wb_valid && (i_wb_rd != '0)) begin
      rf[i_wb_rd] <= i_wb_value;
    end
  end

  // Output bundle: flush beats stall; a held bundle still tracks writebacks to its sources
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_id_valid        <= 1'b0;
      o_id_pc           <= '0;
      o_rs1             <= '0;
      o_rs2             <= '0;
      o_rs1_value       <= '0;
      o_rs2_value       <= '0;
      o_rd              <= '0;
      o_imm_value       <= '0;
      o_alu_command     <= '0;
      o_alu_src_imm     <= 1'b0;
      o_mem_access_type <= '0;
      o_mem_access_size <= '0;
      o_illegal         <= 1'b0;
    end else if (!i_enable || i_flush) begin
      o_id_valid <= 1'b0;
    end else if (!o_stall) begin
      o_id_valid        <= i_if_valid;
      o_id_pc           <= i_if_pc;
      o_rs1             <= dec_rs1;
      o_rs2             <= dec_rs2;
      o_rs1_value       <= rs1_val;
      o_rs2_value       <= rs2_val;
      o_rd              <= dec_rd;
      o_imm_value       <= dec_imm;
      o_alu_command     <= dec_alu;
      o_alu_src_imm     <= dec_src_imm;
      o_mem_access_type <= dec_mem;
      o_mem_access_size <= dec_size;
      o_illegal         <= dec_illegal;
    end else begin
      if (!i_ex_stall) begin
        o_id_valid <= 1'b0;
      end
      if (hold_hit_rs1) begin
        o_rs1_value <= i_wb_value;
      end
      if (hold_hit_rs2) begin
        o_rs2_value <= i_wb_value;
      end
    end
  end

endmodule

// File: tb/tb_rice_core_id_stage.sv
// Randomized self-checking bench for rice_core_id_stage against a cycle-level reference model.
module tb_rice_core_id_stage;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            if_valid;
  logic [31:0]     if_pc;
  logic [31:0]     if_inst;
  logic            stall;
  logic            ex_stall;
  logic            flush;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_value;
  logic            id_valid;
  logic [31:0]     id_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [31:0]     rs1_value;
  logic [31:0]     rs2_value;
  logic [4:0]      rd;
  logic [31:0]     imm_value;
  logic [3:0]      alu_command;
  logic            alu_src_imm;
  logic [1:0]      mem_type;
  logic [2:0]      mem_size;
  logic            illegal;

  rice_core_id_stage #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_if_valid(if_valid), .i_if_pc(if_pc),
    .i_if_inst(if_inst), .o_stall(stall), .i_ex_stall(ex_stall), .i_flush(flush),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_value(wb_value), .o_id_valid(id_valid),
    .o_id_pc(id_pc), .o_rs1(rs1), .o_rs2(rs2), .o_rs1_value(rs1_value),
    .o_rs2_value(rs2_value), .o_rd(rd), .o_imm_value(imm_value),
    .o_alu_command(alu_command), .o_alu_src_imm(alu_src_imm),
    .o_mem_access_type(mem_type), .o_mem_access_size(mem_size), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src_imm;
    logic [1:0]  mtype;
    logic [2:0]  msize;
    logic        ill;
  } dec_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] rf_m [32];
  dec_t        m_d;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_rs1v;
  logic [31:0] m_rs2v;
  logic        last_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] x);
    return {{20{x[11]}}, x};
  endfunction

  // Reference decode straight from the RV32I subset rules
  function automatic dec_t ref_decode(input logic [31:0] inst);
    dec_t        d;
    logic [3:0]  tbl [8];
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          legal;
    tbl   = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
    d     = '0;
    f3    = inst[14:12];
    f7    = inst[31:25];
    legal = 1'b1;
    case (inst[6:0])
      7'h37: begin
        d.rd = inst[11:7]; d.imm = {inst[31:12], 12'h000}; d.alu = 4'd11; d.src_imm = 1'b1;
      end
      7'h13: begin
        d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = sext12(inst[31:20]); d.src_imm = 1'b1;
        d.alu = tbl[f3];
        if (f3 == 3'd5 && f7 == 7'h20) d.alu = 4'd8;
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h33: begin
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.rd = inst[11:7];
        d.alu = tbl[f3];
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (f7 == 7'h20) d.alu = (f3 == 3'd0) ? 4'd2 : 4'd8;
      end
      7'h03: begin
        d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = sext12(inst[31:20]);
        d.mtype = 2'd1; d.msize = f3;
      end
      7'h23: begin
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.imm = sext12({inst[31:25], inst[11:7]});
        d.mtype = 2'd2; d.msize = f3;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d     = '0;
      d.ill = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : rf_m[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    m_d = '0; m_valid = 1'b0; m_pc = '0; m_rs1v = '0; m_rs2v = '0; last_stall = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, id_valid, 0);
    check({tag, "_pc"}, id_pc, 0);
    check({tag, "_rs1"}, rs1, 0);
    check({tag, "_rs2"}, rs2, 0);
    check({tag, "_rs1v"}, rs1_value, 0);
    check({tag, "_rs2v"}, rs2_value, 0);
    check({tag, "_rd"}, rd, 0);
    check({tag, "_imm"}, imm_value, 0);
    check({tag, "_alu"}, alu_command, 0);
    check({tag, "_srcimm"}, alu_src_imm, 0);
    check({tag, "_mtype"}, mem_type, 0);
    check({tag, "_msize"}, mem_size, 0);
    check({tag, "_ill"}, illegal, 0);
  endtask

  task automatic compare_outputs();
    check("valid", id_valid, m_valid);
    if (m_valid) begin
      check("pc", id_pc, m_pc);
      check("rs1", rs1, m_d.rs1);
      check("rs2", rs2, m_d.rs2);
      check("rs1v", rs1_value, m_rs1v);
      check("rs2v", rs2_value, m_rs2v);
      check("rd", rd, m_d.rd);
      check("imm", imm_value, m_d.imm);
      check("alu", alu_command, m_d.alu);
      check("srcimm", alu_src_imm, m_d.src_imm);
      check("mtype", mem_type, m_d.mtype);
      check("msize", mem_size, m_d.msize);
      check("ill", illegal, m_d.ill);
    end
  endtask

  // One clock: entered just after a rising edge with inputs set, leaves 1 unit after the next edge
  task automatic step();
    dec_t        d;
    logic [31:0] v1, v2;
    logic        bub, exp_stall;
    d  = ref_decode(if_inst);
    v1 = rd_model(d.rs1);
    v2 = rd_model(d.rs2);
`ifdef RICE_CORE_ID_RF_BYPASS_EN
    if (wb_valid && wb_rd != 5'd0 && wb_rd == d.rs1) v1 = wb_value;
    if (wb_valid && wb_rd != 5'd0 && wb_rd == d.rs2) v2 = wb_value;
    bub = 1'b0;
`else
    bub = if_valid && wb_valid && wb_rd != 5'd0 && (wb_rd == d.rs1 || wb_rd == d.rs2);
`endif
    exp_stall = ex_stall || bub;
    #2;
    check("stall", stall, exp_stall);
    @(posedge clk);
    if (!en || flush) begin
      m_valid = 1'b0;
    end else if (!exp_stall) begin
      m_valid = if_valid; m_d = d; m_pc = if_pc; m_rs1v = v1; m_rs2v = v2;
    end else begin
      if (!ex_stall) m_valid = 1'b0;
      if (wb_valid && wb_rd != 5'd0 && wb_rd == m_d.rs1) m_rs1v = wb_value;
      if (wb_valid && wb_rd != 5'd0 && wb_rd == m_d.rs2) m_rs2v = wb_value;
    end
    if (wb_valid && wb_rd != 5'd0) rf_m[wb_rd] = wb_value;
    last_stall = exp_stall;
    #1;
    compare_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic exs, input logic fl, input logic wv,
                       input logic [4:0] wrd, input logic [31:0] wval);
    if_valid = v; if_pc = pc; if_inst = inst; ex_stall = exs; flush = fl;
    wb_valid = wv; wb_rd = wrd; wb_value = wval;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] op, f7;
    int         k;
    k  = int'($urandom_range(0, 9));
    f7 = (k < 6) ? 7'h00 : (k < 9) ? 7'h20 : 7'($urandom);
    case ($urandom_range(0, 5))
      0:       op = 7'h37;
      1:       op = 7'h13;
      2:       op = 7'h33;
      3:       op = 7'h03;
      4:       op = 7'h23;
      default: op = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), op};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_all_zero("reset");
    check("reset_stall", stall, 0);
    ex_stall = 1'b1; #1;
    check("reset_stall_ex", stall, 1);
    ex_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ADDI x1,x0,5
    drive(1, 32'h100, 32'h00500093, 0, 0, 0, 0, 0); step();
    check("addi_valid", id_valid, 1);
    check("addi_rd", rd, 1);
    check("addi_imm", imm_value, 5);
    check("addi_alu", alu_command, 1);
    check("addi_srcimm", alu_src_imm, 1);
    check("addi_rs1v", rs1_value, 0);

    // WB x2, then SW x2,4(x1)
    drive(0, 0, 0, 0, 0, 1, 2, 32'hDEADBEEF); step();
    drive(1, 32'h104, 32'h0020A223, 0, 0, 0, 0, 0); step();
    check("sw_mtype", mem_type, 2);
    check("sw_msize", mem_size, 2);
    check("sw_rs2v", rs2_value, 32'hDEADBEEF);
    check("sw_rd", rd, 0);
    check("sw_imm", imm_value, 4);

    // SUB x5,x6,x7 then three EX-stall cycles with a writeback to x6
    drive(1, 32'h108, 32'h407302B3, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h10C, 32'h00000013, 1, 0, (i == 0), 6, 32'h10); step();
    end
    check("sub_hold_valid", id_valid, 1);
    check("sub_hold_alu", alu_command, 2);
    check("sub_hold_rs1v", rs1_value, 32'h10);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();

    // WB x3=7 while ADD x4,x3,x3 decodes
    drive(1, 32'h110, 32'h00318233, 0, 0, 1, 3, 7); step();
`ifdef RICE_CORE_ID_RF_BYPASS_EN
    check("haz_valid", id_valid, 1);
`else
    check("haz_bubble", id_valid, 0);
    drive(1, 32'h110, 32'h00318233, 0, 0, 0, 0, 0); step();
    check("haz_valid", id_valid, 1);
`endif
    check("haz_rs1v", rs1_value, 7);
    check("haz_rs2v", rs2_value, 7);

    // JAL is unsupported; x0 writes are dropped
    drive(1, 32'h114, 32'h0000006F, 0, 0, 0, 0, 0); step();
    check("jal_ill", illegal, 1);
    check("jal_valid", id_valid, 1);
    check("jal_rd", rd, 0);
    check("jal_alu", alu_command, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h1234); step();
    drive(1, 32'h118, 32'h00000433, 0, 0, 0, 0, 0); step();
    check("x0_rs1v", rs1_value, 0);

    // Flush wins over stall
    drive(1, 32'h11C, 32'h00500093, 0, 0, 0, 0, 0); step();
    drive(1, 32'h120, 32'h00100113, 1, 1, 0, 0, 0); step();
    check("flush_valid", id_valid, 0);

    // Randomized traffic; upstream honours o_stall by holding its bundle
    for (int n = 0; n < 2000; n++) begin
      if (!last_stall) begin
        if_valid = ($urandom_range(0, 4) != 0);
        if_pc    = $urandom & 32'hFFFF_FFFC;
        if_inst  = rand_inst();
      end
      en       = ($urandom_range(0, 19) != 0);
      ex_stall = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_value = $urandom;
      step();
    end
    en = 1'b1;

    // Reset asserted between edges clears outputs at once
    drive(1, 32'h200, 32'h00500093, 0, 0, 0, 0, 0); step();
    check("pre_rst_valid", id_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 32'h204, 32'h00210233, 0, 0, 0, 0, 0); step();
    check("post_rst_valid", id_valid, 1);
    check("post_rst_rs1v", rs1_value, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
